// File: rtl/rtc_bus_snoop_pkg.sv
// Shared types and constants for the RTC I2C bus snooper.
package rtc_bus_snoop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    WAIT_STOP
  } state_t;

  // Only these bits of each RTC register carry time digits.
  localparam logic [7:0] SEC_MASK = 8'h7F;
  localparam logic [7:0] MIN_MASK = 8'h7F;
  localparam logic [7:0] HR_MASK  = 8'h3F;

  // Largest legal BCD value of each field.
  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // True when both nibbles are decimal digits and the value is within limit.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/rtc_bus_snoop_bus_sync_edge.sv
// Synchronizes the asynchronous I2C lines and flags SCL rise, START and STOP.
module bus_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;

  // Synchronizer chains plus one history sample for edge detection; idle bus is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_pipe[0] <= scl;
      sda_pipe[0] <= sda;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        scl_pipe[i] <= scl_pipe[i-1];
        sda_pipe[i] <= sda_pipe[i-1];
      end
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  assign scl_s = scl_pipe[SYNC_STAGES-1];
  assign sda_s = sda_pipe[SYNC_STAGES-1];

  // START/STOP need SCL steady high across both samples, so an SDA change
  // landing on the same sample as an SCL edge is treated as a data edge.
  assign scl_rise  = scl_s & ~scl_q;
  assign start_det = scl_s & scl_q &  sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/rtc_bus_snoop.sv
// Passive I2C monitor: captures the RTC sec/min/hr burst read and publishes
// a validated BCD snapshot with a one-cycle update strobe.
module rtc_bus_snoop
  import rtc_bus_snoop_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h68,
  parameter int unsigned N_BYTES     = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl,
  input  logic               sda,
  output logic [7:0]         Seconds,
  output logic [7:0]         Minutes,
  output logic [7:0]         Hours,
  output logic [N_BYTES-1:0] Acknowledge,
  output logic               time_upd,
  output logic               frame_err
);

  localparam int unsigned IDX_W = $clog2(N_BYTES + 1);

  state_t             state;
  state_t             state_nxt;
  logic               sda_s;
  logic               scl_rise;
  logic               start_det;
  logic               stop_det;
  logic [7:0]         shift;
  logic [7:0]         byte_val;
  logic [2:0]         bit_cnt;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         shadow [N_BYTES];
  logic [N_BYTES-1:0] ack_shadow;
  logic               shift_en;
  logic               data_done;
  logic               ack_take;
  logic               addr_nack;
  logic               frame_full;
  logic               frame_ok;

  bus_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign byte_val   = {shift[6:0], sda_s};
  assign frame_full = (idx == IDX_W'(N_BYTES));
  assign frame_ok   = bcd_ok(shadow[0] & SEC_MASK, SEC_MAX)
                   && bcd_ok(shadow[1] & MIN_MASK, MIN_MAX)
                   && bcd_ok(shadow[2] & HR_MASK,  HR_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: START/STOP override everything, otherwise advance on SCL rise.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else if (scl_rise) begin
      unique case (state)
        ADDR:
          if (bit_cnt == 3'd7)
            state_nxt = (byte_val == {DEV_ADDR, 1'b1}) ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:
          state_nxt = sda_s ? WAIT_STOP : DATA;
        DATA:
          if (bit_cnt == 3'd7) state_nxt = DATA_ACK;
        DATA_ACK:
          state_nxt = (idx == IDX_W'(N_BYTES - 1)) ? WAIT_STOP : DATA;
        default: state_nxt = state;
      endcase
    end
  end

  // Per-state datapath controls for the current SCL rise.
  always_comb begin
    shift_en  = 1'b0;
    data_done = 1'b0;
    ack_take  = 1'b0;
    addr_nack = 1'b0;
    if (scl_rise) begin
      unique case (state)
        ADDR:     shift_en  = 1'b1;
        DATA: begin
          shift_en  = 1'b1;
          data_done = (bit_cnt == 3'd7);
        end
        ADDR_ACK: addr_nack = sda_s;
        DATA_ACK: ack_take  = 1'b1;
        default: ;
      endcase
    end
  end

  // Shift/count/shadow capture and the commit-on-STOP validator.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift       <= '0;
      bit_cnt     <= '0;
      idx         <= '0;
      ack_shadow  <= '0;
      for (int unsigned i = 0; i < N_BYTES; i++) shadow[i] <= '0;
      Seconds     <= '0;
      Minutes     <= '0;
      Hours       <= '0;
      Acknowledge <= '0;
      time_upd    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      time_upd <= 1'b0;
      if (start_det || stop_det) begin
        shift   <= '0;
        bit_cnt <= '0;
        idx     <= '0;
      end else begin
        if (shift_en) begin
          shift   <= byte_val;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (data_done) shadow[idx] <= byte_val;
        if (ack_take) begin
          ack_shadow[idx] <= sda_s;
          idx             <= idx + 1'b1;
        end
      end
      if (addr_nack) frame_err <= 1'b1;
      if (stop_det && frame_full) begin
        if (frame_ok) begin
          Seconds     <= shadow[0] & SEC_MASK;
          Minutes     <= shadow[1] & MIN_MASK;
          Hours       <= shadow[2] & HR_MASK;
          Acknowledge <= ack_shadow;
          time_upd    <= 1'b1;
          frame_err   <= 1'b0;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_bus_snoop.sv
// Self-checking bench for rtc_bus_snoop: bit-banged I2C frames, transaction-level model.
`timescale 1ns/1ps
module tb_rtc_bus_snoop;

  localparam int EV_START = 0;
  localparam int EV_BYTE  = 1;
  localparam int EV_STOP  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       ack;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda;
  logic [7:0] Seconds;
  logic [7:0] Minutes;
  logic [7:0] Hours;
  logic [2:0] Acknowledge;
  logic       time_upd;
  logic       frame_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned upd_cnt = 0;

  ev_t        evq[$];
  logic [7:0] m_sec = '0;
  logic [7:0] m_min = '0;
  logic [7:0] m_hr  = '0;
  logic [2:0] m_ack = '0;
  logic       m_err = 1'b0;
  int         m_upd = 0;

  always #5 clk = ~clk;

  rtc_bus_snoop #(
    .DEV_ADDR   (7'h68),
    .N_BYTES    (3),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda),
    .Seconds    (Seconds),
    .Minutes    (Minutes),
    .Hours      (Hours),
    .Acknowledge(Acknowledge),
    .time_upd   (time_upd),
    .frame_err  (frame_err)
  );

  // Count every clock the strobe is high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) if (time_upd === 1'b1) upd_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(posedge clk);
  endtask

  task automatic bus_start();
    if (!(scl === 1'b1 && sda === 1'b1)) begin
      scl = 1'b0; half();
      sda = 1'b1; half();
      scl = 1'b1; half();
    end
    sda = 1'b0; half();
    scl = 1'b0; half();
  endtask

  task automatic bus_bit(input logic b);
    sda = b;    half();
    scl = 1'b1; half();
    scl = 1'b0; half();
  endtask

  task automatic bus_byte(input logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    bus_bit(a);
  endtask

  task automatic bus_stop();
    sda = 1'b0; half();
    scl = 1'b1; half();
    sda = 1'b1; half();
  endtask

  task automatic add_start();
    ev_t e; e.kind = EV_START; e.data = '0; e.ack = 1'b0; evq.push_back(e);
  endtask

  task automatic add_byte(input logic [7:0] d, input logic a);
    ev_t e; e.kind = EV_BYTE; e.data = d; e.ack = a; evq.push_back(e);
  endtask

  task automatic add_stop();
    ev_t e; e.kind = EV_STOP; e.data = '0; e.ack = 1'b0; evq.push_back(e);
  endtask

  task automatic add_read(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    add_start();
    add_byte(8'hD1, 1'b0);
    add_byte(s, 1'b0);
    add_byte(m, 1'b0);
    add_byte(h, 1'b1);
    add_stop();
  endtask

  // Decimal view of a BCD byte: both digits decimal and value within limit.
  function automatic bit bcd_in_range(input logic [7:0] v, input int lim);
    int tens;
    int ones;
    tens = int'(v[7:4]);
    ones = int'(v[3:0]);
    return (tens <= 9) && (ones <= 9) && (tens * 10 + ones <= lim);
  endfunction

  // Walk the frame at transaction level and update the expected snapshot.
  task automatic model_frame();
    bit         expect_addr = 1'b0;
    bit         in_read     = 1'b0;
    int         n           = 0;
    logic [7:0] sh [3];
    logic [2:0] ak = '0;
    for (int k = 0; k < 3; k++) sh[k] = '0;
    foreach (evq[i]) begin
      case (evq[i].kind)
        EV_START: begin expect_addr = 1'b1; in_read = 1'b0; n = 0; end
        EV_BYTE: begin
          if (expect_addr) begin
            expect_addr = 1'b0;
            if (evq[i].data == 8'hD1) begin
              if (evq[i].ack) m_err = 1'b1;
              else            in_read = 1'b1;
            end
          end else if (in_read && n < 3) begin
            sh[n] = evq[i].data;
            ak[n] = evq[i].ack;
            n++;
          end
        end
        default: begin
          if (in_read && n == 3) begin
            if (bcd_in_range(sh[0] & 8'h7F, 59) && bcd_in_range(sh[1] & 8'h7F, 59)
                && bcd_in_range(sh[2] & 8'h3F, 23)) begin
              m_sec = sh[0] & 8'h7F;
              m_min = sh[1] & 8'h7F;
              m_hr  = sh[2] & 8'h3F;
              m_ack = ak;
              m_err = 1'b0;
              m_upd++;
            end else begin
              m_err = 1'b1;
            end
          end
          expect_addr = 1'b0;
          in_read     = 1'b0;
          n           = 0;
        end
      endcase
    end
  endtask

  task automatic check_outputs(input string tag, input int upd_exp);
    check_eq({tag, ".sec"}, 32'(Seconds),     32'(m_sec));
    check_eq({tag, ".min"}, 32'(Minutes),     32'(m_min));
    check_eq({tag, ".hr"},  32'(Hours),       32'(m_hr));
    check_eq({tag, ".ack"}, 32'(Acknowledge), 32'(m_ack));
    check_eq({tag, ".err"}, 32'(frame_err),   32'(m_err));
    check_eq({tag, ".upd"}, 32'(upd_cnt),     32'(upd_exp));
  endtask

  task automatic run_frame(input string tag);
    int upd0;
    upd0  = int'(upd_cnt);
    m_upd = 0;
    foreach (evq[i]) begin
      case (evq[i].kind)
        EV_START: bus_start();
        EV_BYTE:  bus_byte(evq[i].data, evq[i].ack);
        default:  bus_stop();
      endcase
    end
    model_frame();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_outputs(tag, upd0 + m_upd);
    evq.delete();
  endtask

  function automatic logic [7:0] rand_field(input int lim);
    logic [7:0] v;
    int         x;
    if ($urandom_range(0, 3) == 0) begin
      v = 8'($urandom_range(0, 255));
    end else begin
      x    = int'($urandom_range(0, lim));
      v    = 8'(((x / 10) << 4) | (x % 10));
      v[7] = 1'($urandom_range(0, 1));
    end
    return v;
  endfunction

  initial begin
    int nb;
    int r;
    logic [7:0] addr;
    logic [7:0] mb;

    rst = 1'b1;
    scl = 1'b1;
    sda = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Write preamble, repeated START, then a clean burst read.
    add_start(); add_byte(8'hD0, 1'b0); add_byte(8'h00, 1'b0);
    add_start(); add_byte(8'hD1, 1'b0);
    add_byte(8'h45, 1'b0); add_byte(8'h30, 1'b0); add_byte(8'h13, 1'b1);
    add_stop();
    run_frame("basic");
    check_eq("basic.ack_lit", 32'(Acknowledge), 32'h4);
    check_eq("basic.sec_lit", 32'(Seconds), 32'h45);

    add_read(8'hC5, 8'h31, 8'h14);
    run_frame("ch_bit");
    check_eq("ch_bit.sec_lit", 32'(Seconds), 32'h45);

    add_read(8'h46, 8'h6A, 8'h13);
    run_frame("bad_min");
    check_eq("bad_min.err_lit", 32'(frame_err), 32'h1);

    add_read(8'h00, 8'h59, 8'h23);
    run_frame("limits");

    add_start(); add_byte(8'hA1, 1'b1); add_stop();
    run_frame("addr50");
    check_eq("addr50.err_lit", 32'(frame_err), 32'h0);

    add_start(); add_byte(8'hD1, 1'b0); add_byte(8'h11, 1'b0); add_byte(8'h22, 1'b0);
    add_start(); add_byte(8'hD1, 1'b0);
    add_byte(8'h12, 1'b0); add_byte(8'h34, 1'b0); add_byte(8'h21, 1'b1);
    add_stop();
    run_frame("rep_start");

    add_start(); add_byte(8'hD1, 1'b0); add_byte(8'h10, 1'b0); add_stop();
    run_frame("short");

    add_read(8'h60, 8'h00, 8'h00);
    run_frame("bad_sec");
    add_read(8'h00, 8'h00, 8'h24);
    run_frame("bad_hr");

    // Reset in the middle of the minutes byte; bus keeps clocking the rest of the frame.
    bus_start();
    bus_byte(8'hD1, 1'b0);
    bus_byte(8'h45, 1'b0);
    mb = 8'h30;
    for (int i = 7; i >= 4; i--) bus_bit(mb[i]);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_sec = '0; m_min = '0; m_hr = '0; m_ack = '0; m_err = 1'b0;
    check_outputs("in_reset", int'(upd_cnt));
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) bus_bit(mb[i]);
    bus_bit(1'b0);
    bus_byte(8'h13, 1'b1);
    bus_stop();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_outputs("post_reset", int'(upd_cnt));

    add_read(8'h07, 8'h08, 8'h09);
    run_frame("after_rst");

    for (int f = 0; f < 30; f++) begin
      r = int'($urandom_range(0, 9));
      addr = (r == 0) ? 8'hD0 : (r == 1) ? 8'hA1 : 8'hD1;
      add_start();
      add_byte(addr, 1'($urandom_range(0, 9) == 0));
      nb = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(1, 5));
      for (int b = 0; b < nb; b++)
        add_byte(rand_field(b == 2 ? 23 : 59), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) begin
        add_start();
        add_byte(8'hD1, 1'b0);
        for (int b = 0; b < 3; b++)
          add_byte(rand_field(b == 2 ? 23 : 59), 1'($urandom_range(0, 1)));
      end
      add_stop();
      run_frame($sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
